// File: rtl/apb2sysbus.sv
// apb2sysbus: APB3 completer turning each transfer into one toy sysbus
// request/ack pair, with address window check, ack timeout and orphan drain.
package toy_pack;
    localparam logic TOY_BUS_READ  = 1'b0;
    localparam logic TOY_BUS_WRITE = 1'b1;
endpackage

module apb2sysbus
    import toy_pack::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    output logic        bus_req_vld,
    input  logic        bus_req_rdy,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_data,
    output logic [3:0]  bus_req_strb,
    output logic        bus_req_opcode,
    input  logic        bus_ack_vld,
    output logic        bus_ack_rdy,
    input  logic [31:0] bus_ack_data
);
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT_CYCLES - 1);
    localparam logic          TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        RESP,
        DRAIN_REQ,
        DRAIN_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            write_q, write_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic            drain_ack_q, drain_ack_d;
    logic            hit;
    logic            fire;

    // penable carries no information for this completer
    logic unused_penable;
    assign unused_penable = apb_penable;

    assign hit  = (apb_paddr & ADDR_MASK) == ADDR_BASE;
    assign fire = TMO_EN && (cnt_q >= CNT_FIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            drain_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            drain_ack_q <= drain_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        drain_d     = drain_q;
        drain_ack_d = drain_ack_q;
        unique case (state_q)
            IDLE: begin
                if (apb_psel) begin
                    addr_d  = apb_paddr;
                    data_d  = apb_pwdata;
                    write_d = apb_pwrite;
                    err_d   = !hit;
                    state_d = hit ? REQ : RESP;
                end
            end
            REQ: begin
                if (bus_req_rdy) begin
                    state_d = ACK;
                end else if (fire) begin
                    state_d     = RESP;
                    err_d       = 1'b1;
                    drain_d     = 1'b1;
                    drain_ack_d = 1'b0;
                    if (!write_q) rdata_d = '0;
                end
            end
            ACK: begin
                // an ack in the firing cycle still wins
                if (bus_ack_vld) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (!write_q) rdata_d = bus_ack_data;
                end else if (fire) begin
                    state_d     = RESP;
                    err_d       = 1'b1;
                    drain_d     = 1'b1;
                    drain_ack_d = 1'b1;
                    if (!write_q) rdata_d = '0;
                end
            end
            RESP: begin
                if (drain_q) begin
                    state_d = drain_ack_q ? DRAIN_ACK : DRAIN_REQ;
                    drain_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN_REQ: begin
                if (bus_req_rdy) state_d = DRAIN_ACK;
            end
            DRAIN_ACK: begin
                if (bus_ack_vld) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // saturate so a late request handshake cannot wrap the budget
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == REQ || state_q == ACK) && TMO_EN && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        if (state_d == IDLE && state_q != IDLE)
            cnt_d = '0;
    end

    assign bus_req_vld    = (state_q == REQ) || (state_q == DRAIN_REQ);
    assign bus_ack_rdy    = (state_q == ACK) || (state_q == DRAIN_ACK);
    assign bus_req_addr   = addr_q;
    assign bus_req_data   = data_q;
    assign bus_req_strb   = 4'hF;
    assign bus_req_opcode = write_q ? TOY_BUS_WRITE : TOY_BUS_READ;
    assign apb_pready     = (state_q == RESP);
    assign apb_pslverr    = (state_q == RESP) && err_q;
    assign apb_prdata     = (state_q == RESP) ? rdata_q : '0;
endmodule

// File: tb/tb_apb2sysbus.sv
// Bench for apb2sysbus: two instances (open window, narrow window with short
// timeout), a delay-programmable sysbus responder and a transfer-level model.
`timescale 1ns/1ps
module tb_apb2sysbus;
    import toy_pack::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel[2], penable[2], pwrite[2];
    logic [31:0] paddr[2], pwdata[2], prdata[2];
    logic        pready[2], pslverr[2];
    logic        req_vld[2], req_rdy[2], req_op[2];
    logic [31:0] req_addr[2], req_data[2];
    logic [3:0]  req_strb[2];
    logic        ack_vld[2], ack_rdy[2];
    logic [31:0] ack_data[2];

    int          rd_cfg[2], ad_cfg[2];
    logic [31:0] dat_cfg[2];
    int          prdy_cnt[2], hs_cnt[2], vld_cnt[2], unstable[2];
    logic [31:0] hs_addr[2], hs_data[2];
    logic        hs_op[2];
    logic [31:0] rdm[2];

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    apb2sysbus dut0 (
        .clk(clk), .rst_n(rst_n),
        .apb_psel(psel[0]), .apb_penable(penable[0]), .apb_pwrite(pwrite[0]),
        .apb_paddr(paddr[0]), .apb_pwdata(pwdata[0]), .apb_prdata(prdata[0]),
        .apb_pready(pready[0]), .apb_pslverr(pslverr[0]),
        .bus_req_vld(req_vld[0]), .bus_req_rdy(req_rdy[0]),
        .bus_req_addr(req_addr[0]), .bus_req_data(req_data[0]),
        .bus_req_strb(req_strb[0]), .bus_req_opcode(req_op[0]),
        .bus_ack_vld(ack_vld[0]), .bus_ack_rdy(ack_rdy[0]),
        .bus_ack_data(ack_data[0])
    );

    apb2sysbus #(
        .ADDR_BASE(32'h4000_0000),
        .ADDR_MASK(32'hF000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .apb_psel(psel[1]), .apb_penable(penable[1]), .apb_pwrite(pwrite[1]),
        .apb_paddr(paddr[1]), .apb_pwdata(pwdata[1]), .apb_prdata(prdata[1]),
        .apb_pready(pready[1]), .apb_pslverr(pslverr[1]),
        .bus_req_vld(req_vld[1]), .bus_req_rdy(req_rdy[1]),
        .bus_req_addr(req_addr[1]), .bus_req_data(req_data[1]),
        .bus_req_strb(req_strb[1]), .bus_req_opcode(req_op[1]),
        .bus_ack_vld(ack_vld[1]), .bus_ack_rdy(ack_rdy[1]),
        .bus_ack_data(ack_data[1])
    );

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? 32'h4000_0000 : 32'h0;
    endfunction

    function automatic logic [31:0] mask_of(input int d);
        return (d == 1) ? 32'hF000_0000 : 32'h0;
    endfunction

    function automatic int tmo_of(input int d);
        return (d == 1) ? 4 : 256;
    endfunction

    // Sysbus target: ready after rd_cfg wait cycles, ack valid rd
    // ad_cfg cycles after the request handshake, held until taken.
    task automatic responder(input int d);
        int ph = 0;
        int rc = 0;
        int ac = 0;
        int cad = 0;
        forever begin
            @(negedge clk);
            req_rdy[d] = 1'b0;
            ack_vld[d] = 1'b0;
            if (!rst_n) begin
                ph = 0; rc = 0; ac = 0;
            end else if (ph == 0) begin
                if (req_vld[d]) begin
                    if (rc >= rd_cfg[d]) begin
                        req_rdy[d]  = 1'b1;
                        ph = 1; rc = 0; ac = 0;
                        cad         = ad_cfg[d];
                        ack_data[d] = dat_cfg[d];
                    end else begin
                        rc++;
                    end
                end
            end else begin
                if (ac >= cad) begin
                    ack_vld[d] = 1'b1;
                    if (ack_rdy[d]) ph = 0;
                end else begin
                    ac++;
                end
            end
        end
    endtask

    task automatic monitor(input int d);
        logic        held = 1'b0;
        logic [68:0] saved = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (pready[d]) prdy_cnt[d]++;
                if (req_vld[d]) begin
                    vld_cnt[d]++;
                    if (held && saved !== {req_addr[d], req_data[d], req_op[d], req_strb[d]})
                        unstable[d]++;
                    saved = {req_addr[d], req_data[d], req_op[d], req_strb[d]};
                    held  = !req_rdy[d];
                    if (req_rdy[d]) begin
                        hs_cnt[d]++;
                        hs_addr[d] = req_addr[d];
                        hs_data[d] = req_data[d];
                        hs_op[d]   = req_op[d];
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    endtask

    initial responder(0);
    initial responder(1);
    initial monitor(0);
    initial monitor(1);

    // lat = negedges from setup until pready seen; -1 when it never comes
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rdat,
                            output logic er, output int lat);
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0;
        pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        lat = 0; rdat = '0; er = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            penable[d] = 1'b1;
            if (pready[d]) begin
                rdat = prdata[d];
                er   = pslverr[d];
                break;
            end
            if (lat >= 200) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic apb_idle(input int d, input int n);
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic set_bus(input int d, input int r, input int a, input logic [31:0] v);
        rd_cfg[d] = r; ad_cfg[d] = a; dat_cfg[d] = v;
    endtask

    // Transfer outcome from the block's rules, not its state machine
    task automatic model(input int d, input logic wr, input logic [31:0] a,
                         input int rdly, input int adly, input logic [31:0] dat,
                         output int lat, output logic [31:0] rdat,
                         output logic er, output logic hit);
        int t;
        t   = tmo_of(d);
        hit = (a & mask_of(d)) == base_of(d);
        if (!hit) begin
            lat = 1; er = 1'b1;
        end else if (t != 0 && rdly + adly + 2 > t) begin
            lat = t + 1; er = 1'b1;
            if (!wr) rdm[d] = '0;
        end else begin
            lat = 3 + rdly + adly; er = 1'b0;
            if (!wr) rdm[d] = dat;
        end
        rdat = rdm[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            ntests++;
            if ({pready[d], pslverr[d], req_vld[d], ack_rdy[d], req_op[d], req_strb[d],
                 prdata[d], req_addr[d], req_data[d]} !==
                {4'b0, TOY_BUS_READ, 4'hF, 96'h0}) begin
                nfail++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b err=%b vld=%b ackrdy=%b op=%b strb=%h rd=%h a=%h wd=%h",
                         d, pready[d], pslverr[d], req_vld[d], ack_rdy[d], req_op[d],
                         req_strb[d], prdata[d], req_addr[d], req_data[d]);
            end
        end
    endtask

    task automatic test_read();
        logic [31:0] rdat;
        logic er;
        int lat;
        set_bus(0, 0, 0, 32'hDEAD_BEEF);
        apb_xfer(0, 1'b0, 32'h0000_1000, 32'h0, rdat, er, lat);
        apb_idle(0, 2);
        rdm[0] = 32'hDEAD_BEEF;
        ntests++;
        if ({lat, er, rdat} !== {32'd3, 1'b0, 32'hDEAD_BEEF}) begin
            nfail++;
            $display("FAIL read_zero_wait: lat=%0d err=%b data=%h, want lat=3 err=0 data=deadbeef",
                     lat, er, rdat);
        end
        ntests++;
        if ({hs_op[0], hs_addr[0]} !== {TOY_BUS_READ, 32'h0000_1000}) begin
            nfail++;
            $display("FAIL read_req_fields: op=%b addr=%h, want op=%b addr=00001000",
                     hs_op[0], hs_addr[0], TOY_BUS_READ);
        end
    endtask

    task automatic test_write_stall();
        logic [31:0] rdat;
        logic er;
        int lat, p0, u0;
        p0 = prdy_cnt[0];
        u0 = unstable[0];
        set_bus(0, 3, 1, 32'h0BAD_0BAD);
        apb_xfer(0, 1'b1, 32'h0000_2004, 32'hA5A5_5A5A, rdat, er, lat);
        apb_idle(0, 3);
        ntests++;
        if ({lat, er} !== {32'd7, 1'b0}) begin
            nfail++;
            $display("FAIL write_stall_latency: lat=%0d err=%b, want lat=7 err=0", lat, er);
        end
        ntests++;
        if (rdat !== rdm[0]) begin
            nfail++;
            $display("FAIL write_prdata_kept: got %h, want %h", rdat, rdm[0]);
        end
        ntests++;
        if ({hs_op[0], hs_addr[0], hs_data[0]} !==
            {TOY_BUS_WRITE, 32'h0000_2004, 32'hA5A5_5A5A}) begin
            nfail++;
            $display("FAIL write_req_fields: op=%b addr=%h data=%h", hs_op[0], hs_addr[0], hs_data[0]);
        end
        ntests++;
        if ({prdy_cnt[0] - p0, unstable[0] - u0} !== {32'd1, 32'd0}) begin
            nfail++;
            $display("FAIL write_pready_once_stable: pready=%0d unstable=%0d, want 1 and 0",
                     prdy_cnt[0] - p0, unstable[0] - u0);
        end
    endtask

    task automatic test_window_miss();
        logic [31:0] rdat;
        logic er;
        int lat, v0;
        v0 = vld_cnt[1];
        set_bus(1, 0, 0, 32'h1234_5678);
        apb_xfer(1, 1'b0, 32'h5000_0000, 32'h0, rdat, er, lat);
        apb_idle(1, 4);
        ntests++;
        if ({lat, er} !== {32'd1, 1'b1}) begin
            nfail++;
            $display("FAIL window_miss: lat=%0d err=%b, want lat=1 err=1", lat, er);
        end
        ntests++;
        if (vld_cnt[1] - v0 !== 0) begin
            nfail++;
            $display("FAIL window_miss_no_bus: req_vld cycles=%0d, want 0", vld_cnt[1] - v0);
        end
    endtask

    task automatic test_timeout_back_to_back();
        logic [31:0] rdat;
        logic er;
        int lat, h0;
        h0 = hs_cnt[1];
        set_bus(1, 0, 6, 32'h1111_1111);
        apb_xfer(1, 1'b0, 32'h4000_0010, 32'h0, rdat, er, lat);
        ntests++;
        if ({lat, er, rdat} !== {32'd5, 1'b1, 32'h0}) begin
            nfail++;
            $display("FAIL timeout_read: lat=%0d err=%b data=%h, want lat=5 err=1 data=0",
                     lat, er, rdat);
        end
        // orphan ack lands 2 cycles into the next transfer, then 3-cycle path
        set_bus(1, 0, 0, 32'hCAFE_F00D);
        apb_xfer(1, 1'b0, 32'h4000_0020, 32'h0, rdat, er, lat);
        apb_idle(1, 4);
        rdm[1] = 32'hCAFE_F00D;
        ntests++;
        if ({lat, er, rdat} !== {32'd6, 1'b0, 32'hCAFE_F00D}) begin
            nfail++;
            $display("FAIL drain_back_to_back: lat=%0d err=%b data=%h, want lat=6 err=0 data=cafef00d",
                     lat, er, rdat);
        end
        ntests++;
        if ({hs_cnt[1] - h0, hs_addr[1]} !== {32'd2, 32'h4000_0020}) begin
            nfail++;
            $display("FAIL drain_handshakes: count=%0d addr=%h, want 2 and 40000020",
                     hs_cnt[1] - h0, hs_addr[1]);
        end
    endtask

    task automatic test_ack_at_fire();
        logic [31:0] rdat;
        logic er;
        int lat;
        set_bus(1, 0, 2, 32'h600D_DA7A);
        apb_xfer(1, 1'b0, 32'h4000_0030, 32'h0, rdat, er, lat);
        apb_idle(1, 4);
        rdm[1] = 32'h600D_DA7A;
        ntests++;
        if ({lat, er, rdat} !== {32'd5, 1'b0, 32'h600D_DA7A}) begin
            nfail++;
            $display("FAIL ack_at_fire: lat=%0d err=%b data=%h, want lat=5 err=0 data=600dda7a",
                     lat, er, rdat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rdat;
        logic er;
        int lat;
        set_bus(0, 0, 20, 32'h0000_00AA);
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h0000_3000;
        @(negedge clk);
        penable[0] = 1'b1;
        @(negedge clk);
        ntests++;
        if (ack_rdy[0] !== 1'b1) begin
            nfail++;
            $display("FAIL reset_mid_in_ack: ack_rdy=%b, want 1", ack_rdy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        ntests++;
        if ({pready[0], pslverr[0], req_vld[0], ack_rdy[0], req_op[0], req_strb[0],
             prdata[0], req_addr[0], req_data[0]} !==
            {4'b0, TOY_BUS_READ, 4'hF, 96'h0}) begin
            nfail++;
            $display("FAIL reset_mid_outputs: vld=%b ackrdy=%b addr=%h rdy=%b",
                     req_vld[0], ack_rdy[0], req_addr[0], pready[0]);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        rdm[0] = '0;
        rdm[1] = '0;
        set_bus(0, 0, 0, 32'h7E57_0001);
        apb_xfer(0, 1'b0, 32'h0000_3004, 32'h0, rdat, er, lat);
        apb_idle(0, 2);
        rdm[0] = 32'h7E57_0001;
        ntests++;
        if ({lat, er, rdat} !== {32'd3, 1'b0, 32'h7E57_0001}) begin
            nfail++;
            $display("FAIL reset_mid_fresh_read: lat=%0d err=%b data=%h, want 3 0 7e570001",
                     lat, er, rdat);
        end
    endtask

    task automatic test_random(input int d);
        logic [31:0] a, wd, dat, rdat, erdat;
        logic wr, er, eer, hit;
        int rdly, adly, lat, elat, p0, h0;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom_range(0, 1));
            rdly = $urandom_range(0, 2);
            adly = $urandom_range(0, 3);
            a    = $urandom;
            if (d == 1 && $urandom_range(0, 2) != 0) a[31:28] = 4'h4;
            wd   = $urandom;
            dat  = $urandom;
            set_bus(d, rdly, adly, dat);
            p0 = prdy_cnt[d];
            h0 = hs_cnt[d];
            model(d, wr, a, rdly, adly, dat, elat, erdat, eer, hit);
            apb_xfer(d, wr, a, wd, rdat, er, lat);
            apb_idle(d, 8);
            ntests++;
            if ({lat, er, rdat} !== {elat, eer, erdat}) begin
                nfail++;
                $display("FAIL random_xfer dut%0d #%0d wr=%b a=%h rd=%0d ad=%0d: lat=%0d err=%b data=%h, want lat=%0d err=%b data=%h",
                         d, i, wr, a, rdly, adly, lat, er, rdat, elat, eer, erdat);
            end
            ntests++;
            if ({prdy_cnt[d] - p0, hs_cnt[d] - h0} !== {32'd1, hit ? 32'd1 : 32'd0}) begin
                nfail++;
                $display("FAIL random_counts dut%0d #%0d: pready=%0d handshakes=%0d, want 1 and %0d",
                         d, i, prdy_cnt[d] - p0, hs_cnt[d] - h0, hit);
            end
            if (hit) begin
                ntests++;
                if ({hs_addr[d], hs_op[d]} !== {a, wr ? TOY_BUS_WRITE : TOY_BUS_READ}) begin
                    nfail++;
                    $display("FAIL random_req_fields dut%0d #%0d: addr=%h op=%b, want %h %b",
                             d, i, hs_addr[d], hs_op[d], a, wr);
                end
            end
        end
        ntests++;
        if (unstable[d] !== 0) begin
            nfail++;
            $display("FAIL req_stability dut%0d: %0d unstable cycles, want 0", d, unstable[d]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0;
            req_rdy[d] = 1'b0; ack_vld[d] = 1'b0; ack_data[d] = '0;
            rd_cfg[d] = 0; ad_cfg[d] = 0; dat_cfg[d] = '0;
            prdy_cnt[d] = 0; hs_cnt[d] = 0; vld_cnt[d] = 0; unstable[d] = 0;
            hs_addr[d] = '0; hs_data[d] = '0; hs_op[d] = 1'b0;
            rdm[d] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_read();
        test_write_stall();
        test_window_miss();
        test_timeout_back_to_back();
        test_ack_at_fire();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
